// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell is reused over WIDTH
// cycles, with a Start/Busy/Done handshake and signed/unsigned status flags.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MSB_CNT  = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Returns {carry_out, sum} of a one-bit full adder.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic [WIDTH-1:0] r_res_sh;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cin_msb;
  logic             r_carry_out;
  logic             r_overflow;
  logic [1:0]       w_fa;
  logic             w_sum;
  logic             w_cout;
  logic             w_last;

  assign w_fa   = full_add(r_sha[0], r_shb[0], r_carry);
  assign w_sum  = w_fa[0];
  assign w_cout = w_fa[1];
  assign w_last = (r_cnt == LAST_CNT);

  assign Result   = r_result;
  assign CarryOut = r_carry_out;
  assign Overflow = r_overflow;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_RUN;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (r_state)
      ST_RUN:  Busy = 1'b1;
      ST_DONE: Done = 1'b1;
      default: begin
        Busy = 1'b0;
        Done = 1'b0;
      end
    endcase
  end

  // Subtraction is A + ~B + 1, so B is inverted at load and the carry seeded to 1.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sha       <= '0;
      r_shb       <= '0;
      r_res_sh    <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_cin_msb   <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_sha   <= OpA;
            r_shb   <= Sub ? ~OpB : OpB;
            r_carry <= Sub ? 1'b1 : Cin;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_sha    <= {1'b0, r_sha[WIDTH-1:1]};
          r_shb    <= {1'b0, r_shb[WIDTH-1:1]};
          r_res_sh <= {w_sum, r_res_sh[WIDTH-1:1]};
          r_carry  <= w_cout;
          if (r_cnt == MSB_CNT) r_cin_msb <= w_cout;
          if (w_last) begin
            r_result    <= {w_sum, r_res_sh[WIDTH-1:1]};
            r_carry_out <= w_cout;
            r_overflow  <= r_cin_msb ^ w_cout;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule
